// File: rtl/square_wave_gen.sv
// square_wave_gen: multi-channel PWM / square-wave generator.
// Each channel owns a period/duty pair that is double-buffered (shadow ->
// active at each period boundary) plus an enable/invert control register.
// wave and wrap are registered so no input reaches an output combinationally.
`timescale 1ns/1ps

module square_wave_gen #(
    parameter  int CHANNELS = 2,
    parameter  int WIDTH    = 8,
    localparam int AW       = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] wave,
    output logic [CHANNELS-1:0] wrap
);

    // Register selects within a channel's address window.
    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_DUTY   = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;

    // Channel-index field width; a single-channel build has no index bits.
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [IW-1:0] wr_ch;
    logic [1:0]    wr_sel;

    assign wr_sel = wr_addr[1:0];

    generate
        if (CHANNELS > 1) begin : g_idx
            assign wr_ch = wr_addr[AW-1:2];
        end else begin : g_idx_single
            assign wr_ch = '0;
        end
    endgenerate

    // Indices that match no generated channel (>= CHANNELS) simply select
    // nothing, so such writes fall away without any extra range check.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] p_sh;
        logic [WIDTH-1:0] d_sh;
        logic [WIDTH-1:0] p_act;
        logic [WIDTH-1:0] d_act;
        logic [WIDTH-1:0] cnt;
        logic             en;
        logic             inv;
        logic             wave_q;
        logic             wrap_q;

        logic             hit;
        logic             wr_p;
        logic             wr_d;
        logic             wr_c;
        logic             at_end;
        logic             turn_on;
        logic             turn_off;
        logic [WIDTH-1:0] p_next;
        logic [WIDTH-1:0] d_next;

        assign hit      = wr_en && (wr_ch == IW'(ch));
        assign wr_p     = hit && (wr_sel == SEL_PERIOD);
        assign wr_d     = hit && (wr_sel == SEL_DUTY);
        assign wr_c     = hit && (wr_sel == SEL_CTRL);
        assign turn_on  = wr_c && !en &&  wr_data[0];
        assign turn_off = wr_c &&  en && !wr_data[0];
        assign at_end   = (cnt == p_act);

        // Forward a shadow write landing on a wrap edge straight into the
        // active copy, so the freshly written value is not lost for a period.
        assign p_next = wr_p ? wr_data : p_sh;
        assign d_next = wr_d ? wr_data : d_sh;

        // Shadow and control registers: plain write-port captures.
        // NOTE: every clocked block uses non-blocking (<=) assignments so all
        // flops sample pre-edge values; the asynchronous reset clears each
        // register directly, outputs included, without waiting for clk.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_sh <= '0;
                d_sh <= '0;
                en   <= 1'b0;
                inv  <= 1'b0;
            end else begin
                if (wr_p) p_sh <= wr_data;
                if (wr_d) d_sh <= wr_data;
                if (wr_c) begin
                    en  <= wr_data[0];
                    inv <= wr_data[1];
                end
            end
        end

        // Period counter and active period/duty, reloaded at each boundary
        // and on enable; disabling parks the counter at 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                p_act <= '0;
                d_act <= '0;
            end else if (turn_on) begin
                cnt   <= '0;
                p_act <= p_next;
                d_act <= d_next;
            end else if (turn_off) begin
                cnt   <= '0;
            end else if (en) begin
                if (at_end) begin
                    cnt   <= '0;
                    p_act <= p_next;
                    d_act <= d_next;
                end else begin
                    cnt   <= cnt + WIDTH'(1);
                end
            end
        end

        // Registered outputs, one cycle behind the counter they decode.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wave_q <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                wave_q <= en & ((cnt < d_act) ^ inv);
                wrap_q <= en & at_end;
            end
        end

        assign wave[ch] = wave_q;
        assign wrap[ch] = wrap_q;
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen (3 channels so that an
// out-of-range channel index exists). Each test pushes expected
// {wave, wrap} vectors into a scoreboard queue and pops one per clock.
`timescale 1ns/1ps

module tb_square_wave_gen;

    localparam int CH = 3;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [CH-1:0] wave;
    logic [CH-1:0] wrap;

    typedef struct packed {
        logic [CH-1:0] wave;
        logic [CH-1:0] wrap;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    square_wave_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wave    (wave),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [3:0] addr_of(input int ch, input int sel);
        logic [1:0] c;
        logic [1:0] s;
        c = ch[1:0];
        s = sel[1:0];
        return {c, s};
    endfunction

    task automatic push_exp(input logic [CH-1:0] w, input logic [CH-1:0] r);
        exp_t e;
        e.wave = w;
        e.wrap = r;
        sb.push_back(e);
    endtask

    // One clock: drive the write port, take the edge, sample 1 ns later.
    task automatic tick(input logic we, input logic [3:0] a, input logic [W-1:0] d);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 4'd0, '0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic program_ch(input int ch, input int p, input int d);
        tick(1'b1, addr_of(ch, 0), W'(p));
        tick(1'b1, addr_of(ch, 1), W'(d));
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) push_exp('0, '0);
        for (int c = 0; c < 3; c++) begin
            idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL reset_idle c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
        // Run channel 0 (P=3, D=2) and hit reset while wave is high.
        program_ch(0, 3, 2);
        tick(1'b1, addr_of(0, 2), 8'h01);
        push_exp(3'b001, 3'b000);
        idle();
        e = sb.pop_front();
        total_cnt++;
        if (wave !== e.wave || wrap !== e.wrap)
            $display("FAIL reset_prerun wave=%b wrap=%b expected wave=%b wrap=%b", wave, wrap, e.wave, e.wrap);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        push_exp('0, '0);
        e = sb.pop_front();
        total_cnt++;
        if (wave !== e.wave || wrap !== e.wrap)
            $display("FAIL reset_async wave=%b wrap=%b expected wave=%b wrap=%b", wave, wrap, e.wave, e.wrap);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) push_exp('0, '0);
        for (int c = 0; c < 6; c++) begin
            idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL reset_silent c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
        // Shadows were cleared: enabling gives P=0 (wrap always) and D=0.
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 0; c < 4; c++) push_exp(3'b000, 3'b001);
        for (int c = 0; c < 4; c++) begin
            idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL reset_cleared c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic_pwm();
        exp_t e;
        do_reset();
        program_ch(0, 3, 2);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int k = 0; k < 3; k++) begin
            push_exp(3'b001, 3'b000);
            push_exp(3'b001, 3'b000);
            push_exp(3'b000, 3'b000);
            push_exp(3'b000, 3'b001);
        end
        for (int c = 1; c <= 12; c++) begin
            idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL basic_pwm c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_double_buffer();
        exp_t        e;
        logic [19:0] pw;
        logic [19:0] pr;
        pw = 20'b1100_1111_1100_1111_1000;
        pr = 20'b0001_0000_0001_0001_0001;
        do_reset();
        program_ch(0, 3, 2);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 1; c <= 20; c++) push_exp({2'b00, pw[20-c]}, {2'b00, pr[20-c]});
        for (int c = 1; c <= 20; c++) begin
            if (c == 2)       tick(1'b1, addr_of(0, 0), 8'd7);
            else if (c == 3)  tick(1'b1, addr_of(0, 1), 8'd6);
            else if (c == 12) tick(1'b1, addr_of(0, 0), 8'd3);
            else if (c == 16) tick(1'b1, addr_of(0, 1), 8'd1);
            else              idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL double_buffer c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_edge_duty();
        exp_t e;
        logic hi;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            hi = (pass == 1);
            program_ch(0, 7, hi ? 9 : 0);
            tick(1'b1, addr_of(0, 2), 8'h01);
            for (int c = 1; c <= 10; c++) push_exp({2'b00, hi}, {2'b00, ((c - 1) % 8) == 7});
            for (int c = 1; c <= 10; c++) begin
                idle();
                e = sb.pop_front();
                total_cnt++;
                if (wave !== e.wave || wrap !== e.wrap)
                    $display("FAIL edge_duty d=%0d c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", hi ? 9 : 0, c, wave, wrap, e.wave, e.wrap);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_invert();
        exp_t        e;
        logic [11:0] pw;
        logic [11:0] pr;
        pw = 12'b1100_1011_0011;
        pr = 12'b0001_0001_0001;
        do_reset();
        program_ch(0, 3, 2);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 1; c <= 12; c++) push_exp({2'b00, pw[12-c]}, {2'b00, pr[12-c]});
        for (int c = 1; c <= 12; c++) begin
            if (c == 5) tick(1'b1, addr_of(0, 2), 8'h03);
            else        idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL invert c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_disable_reenable();
        exp_t        e;
        logic [11:0] pw;
        logic [11:0] pr;
        pw = 12'b1100_0001_0101;
        pr = 12'b0000_0000_1010;
        do_reset();
        program_ch(0, 3, 2);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 1; c <= 12; c++) push_exp({2'b00, pw[12-c]}, {2'b00, pr[12-c]});
        for (int c = 1; c <= 12; c++) begin
            if (c == 2)      tick(1'b1, addr_of(0, 2), 8'h02);
            else if (c == 4) tick(1'b1, addr_of(0, 0), 8'd1);
            else if (c == 5) tick(1'b1, addr_of(0, 1), 8'd1);
            else if (c == 7) tick(1'b1, addr_of(0, 2), 8'h01);
            else             idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL disable_reenable c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_independence();
        exp_t e;
        logic w0, r0, w1, r1;
        do_reset();
        program_ch(0, 1, 1);
        program_ch(1, 4, 1);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 1; c <= 15; c++) begin
            w0 = (c % 2) == 1;
            r0 = (c % 2) == 0;
            w1 = (c >= 2) && (((c - 2) % 5) == 0);
            r1 = (c >= 2) && (((c - 2) % 5) == 4);
            push_exp({1'b0, w1, w0}, {1'b0, r1, r0});
        end
        for (int c = 1; c <= 15; c++) begin
            if (c == 1)      tick(1'b1, addr_of(1, 2), 8'h01);
            else if (c == 4) tick(1'b1, addr_of(3, 2), 8'h01);
            else if (c == 6) tick(1'b1, addr_of(0, 3), 8'h00);
            else if (c == 8) tick(1'b1, addr_of(3, 0), 8'h00);
            else             idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL independence c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_period();
        exp_t e;
        int   ph;
        int   duty;
        do_reset();
        program_ch(0, 255, 128);
        tick(1'b1, addr_of(0, 2), 8'h01);
        for (int c = 1; c <= 330; c++) begin
            ph   = (c - 1) % 256;
            duty = (c <= 256) ? 128 : 64;
            push_exp({2'b00, ph < duty}, {2'b00, ph == 255});
        end
        for (int c = 1; c <= 330; c++) begin
            if (c == 10) tick(1'b1, addr_of(0, 1), 8'd64);
            else         idle();
            e = sb.pop_front();
            total_cnt++;
            if (wave !== e.wave || wrap !== e.wrap)
                $display("FAIL full_period c=%0d wave=%b wrap=%b expected wave=%b wrap=%b", c, wave, wrap, e.wave, e.wrap);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_double_buffer();
        test_edge_duty();
        test_invert();
        test_disable_reenable();
        test_independence();
        test_full_period();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
